player_motion_ctl: RTL and testbench
====================================

# player_motion_ctl

Parametrised successor to the single-player movement FSM. Turns synchronous key levels (`key_a`, `key_d`, `key_w`) into a character position for the sprite/draw pipeline. Horizontal motion has clamped bounds. Vertical motion follows a jump/gravity model with signed velocity and a ground/ceiling clamp. All updates occur on an internal motion tick derived from the system clock. Sits between the keyboard decoder and the sprite renderer in the 65 MHz/÷10 pixel-clock domain.

## Interface
- `W`, 12: position width (unsigned screen coordinates).
- `TICK_DIV`, 100000: clocks per motion tick; must be ≥ 2.
- `X_MIN`, 0: minimum `pos_x`.
- `X_MAX`, 1000: maximum `pos_x`.
- `X_START`, 50: reset `pos_x`.
- `Y_TOP`, 0: ceiling, the minimum `pos_y`.
- `Y_GROUND`, 500: floor, the maximum `pos_y` and reset value.
- `WALK_STEP`, 2: pixels per tick horizontally.
- `JUMP_V0`, 12: initial upward speed, in pixels per tick.
- `GRAVITY`, 1: velocity increment per tick.
- `VMAX_FALL`, 16: terminal downward speed.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `key_a`, in, 1: move left, level. Synchronous to `clk`.
- `key_d`, in, 1: move right, level.
- `key_w`, in, 1: jump, level. Only the rising edge triggers a jump.
- `pos_x`, out, W: character x.
- `pos_y`, out, W: character y. The y axis grows downward.
- `airborne`, out, 1: 1 in RISE or FALL.
- `facing_left`, out, 1: last horizontal direction taken.
- `tick`, out, 1: one-clock pulse on each motion update.

## Operation
- Tick counter runs 0..`TICK_DIV`-1 and wraps.
  - `tick`=1 while the count equals `TICK_DIV`-1.
  - Positions, velocity and state update on that edge only.
- Jump-edge detect:
  - `key_w` is registered every clock.
  - A rising edge sets sticky `jump_req`.
  - `jump_req` is consumed (cleared) on the next tick, whether or not the jump is granted.
- Horizontal, per tick:
  - `key_d` alone: `pos_x` = min(`pos_x`+`WALK_STEP`, `X_MAX`); `facing_left`=0.
  - `key_a` alone: `pos_x` = max(`pos_x`−`WALK_STEP`, `X_MIN`); `facing_left`=1.
  - Both or neither: hold `pos_x` and `facing_left`.
  - Compute with one guard bit; no wrap below 0 or above 2^W−1.
- Vertical FSM, signed velocity `vy` of W+1 bits:
  - **GROUND**: `vy`=0, `pos_y`=`Y_GROUND`. On tick with `jump_req`: `pos_y` −= `JUMP_V0`, `vy` = −`JUMP_V0`+`GRAVITY`, go to RISE.
  - **RISE**: each tick `pos_y` += `vy`, `vy` += `GRAVITY`.
    - If the new `vy` ≥ 0, go to FALL.
    - If `pos_y`+`vy` < `Y_TOP`: clamp `pos_y`=`Y_TOP`, `vy`=0, go to FALL.
  - **FALL**: each tick `pos_y` += `vy`, then `vy` = min(`vy`+`GRAVITY`, `VMAX_FALL`).
    - If `pos_y`+`vy` ≥ `Y_GROUND`: `pos_y`=`Y_GROUND`, `vy`=0, go to GROUND (landing).
- Horizontal and vertical updates are independent on the same tick; walking while airborne is allowed.
- Holding `key_w` does not re-jump after landing. The key must be released and pressed again.

## Timing
- Reset values, applied immediately on `rst_n`=0 including mid-jump:
  - `pos_x`=`X_START`, `pos_y`=`Y_GROUND`.
  - `airborne`=0, `facing_left`=0, `tick`=0.
  - Counter=0, `jump_req`=0, `vy`=0, state GROUND.
- First `tick` comes `TICK_DIV` clocks after `rst_n` deasserts.
- Outputs are registered. They change one clock after the edge where `tick`=1 is sampled high, i.e. coincident with the counter wrap.
- A key press lasting less than a tick still causes a jump (`jump_req` is sticky). A `key_a`/`key_d` press shorter than a tick and not held at the tick edge is ignored.
- A `key_w` edge on the same clock as the tick is included in that tick.

## Configuration
- `PLAYER_MOTION_DOUBLE_JUMP_EN` defined:
  - One extra jump is allowed per airborne period.
  - A `jump_req` in RISE or FALL with the unused flag set reloads `vy` = −`JUMP_V0`+`GRAVITY`, applies `pos_y` −= `JUMP_V0`, enters RISE and marks the flag used.
  - The flag clears on landing and on reset.
- Not defined: `jump_req` while airborne is discarded. Single jump only.

## Test plan
Bench parameters: `TICK_DIV`=4, `X_START`=50, `X_MAX`=100, `Y_GROUND`=500, `JUMP_V0`=12, `GRAVITY`=1, `WALK_STEP`=2.

- Hold `key_d` for 10 ticks → `pos_x`=70, `facing_left`=0. Hold for 30 ticks → `pos_x` saturates at 100 and stays.
- Hold `key_a` and `key_d` together for 5 ticks → `pos_x` unchanged, `facing_left` unchanged.
- Single `key_w` pulse of 1 clock → apex `pos_y`=422 at tick 12; landing `pos_y`=500 with `airborne`=0 at tick 25.
- Hold `key_w` through landing → no second jump until `key_w` is released and pressed again.
- Pulse `key_w` again at tick 5 of a jump:
  - Macro off → ignored; landing still at tick 25.
  - Macro on → `vy` reloads, `pos_y` decreases by 12 that tick.
  - A third press while airborne is ignored.
- Assert `rst_n`=0 mid-jump (`pos_y`=450, `pos_x`=60) → outputs return to 50/500, `airborne`=0, with no clock edge required.

Source files
------------

// File: rtl/player_motion_ctl.sv
// Player movement controller: key levels to clamped x position and jump/gravity y position.
// Optional second mid-air jump enabled by defining PLAYER_MOTION_DOUBLE_JUMP_EN.
module player_motion_ctl #(
    parameter int W         = 12,
    parameter int TICK_DIV  = 100000,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 1000,
    parameter int X_START   = 50,
    parameter int Y_TOP     = 0,
    parameter int Y_GROUND  = 500,
    parameter int WALK_STEP = 2,
    parameter int JUMP_V0   = 12,
    parameter int GRAVITY   = 1,
    parameter int VMAX_FALL = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_a,
    input  logic         key_d,
    input  logic         key_w,
    output logic [W-1:0] pos_x,
    output logic [W-1:0] pos_y,
    output logic         airborne,
    output logic         facing_left,
    output logic         tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    localparam logic [W-1:0] X_MIN_P    = W'(X_MIN);
    localparam logic [W-1:0] X_MAX_P    = W'(X_MAX);
    localparam logic [W-1:0] X_START_P  = W'(X_START);
    localparam logic [W-1:0] Y_TOP_P    = W'(Y_TOP);
    localparam logic [W-1:0] Y_GROUND_P = W'(Y_GROUND);
    localparam logic [W:0]   STEP_G     = (W+1)'(WALK_STEP);
    localparam logic [W:0]   X_MIN_G    = (W+1)'(X_MIN);
    localparam logic [W:0]   X_MAX_G    = (W+1)'(X_MAX);

    localparam logic signed [W+1:0] Y_TOP_S    = (W+2)'(Y_TOP);
    localparam logic signed [W+1:0] Y_GROUND_S = (W+2)'(Y_GROUND);
    localparam logic signed [W+1:0] JUMP_S     = (W+2)'(JUMP_V0);
    localparam logic signed [W:0]   VY_JUMP    = (W+1)'(GRAVITY - JUMP_V0);
    localparam logic signed [W:0]   VY_GRAV    = (W+1)'(GRAVITY);
    localparam logic signed [W:0]   VY_MAX     = (W+1)'(VMAX_FALL);

    typedef enum logic [1:0] {
        ST_GROUND,
        ST_RISE,
        ST_FALL
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tick_q, tick_d;
    logic                key_w_q;
    logic                jump_req_q, jump_req_d;
    logic [W-1:0]        pos_x_q, pos_x_d;
    logic [W-1:0]        pos_y_q, pos_y_d;
    logic signed [W:0]   vy_q, vy_d;
    logic                facing_q, facing_d;

    logic                jump_now;
    logic                dj_avail;
    logic [W:0]          x_inc, x_dec;
    logic signed [W+1:0] y_sum, y_jump;
    logic signed [W:0]   vy_grav;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_GROUND;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            key_w_q    <= 1'b0;
            jump_req_q <= 1'b0;
            pos_x_q    <= X_START_P;
            pos_y_q    <= Y_GROUND_P;
            vy_q       <= '0;
            facing_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            key_w_q    <= key_w;
            jump_req_q <= jump_req_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            vy_q       <= vy_d;
            facing_q   <= facing_d;
        end
    end

`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
    logic dj_used_q, dj_used_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dj_used_q <= 1'b0;
        else        dj_used_q <= dj_used_d;
    end

    // Spent by a mid-air jump, rearmed on landing.
    always_comb begin
        dj_used_d = dj_used_q;
        if (tick_q && state_q != ST_GROUND) begin
            if (jump_now && !dj_used_q) dj_used_d = 1'b1;
            else if (state_d == ST_GROUND) dj_used_d = 1'b0;
        end
    end

    assign dj_avail = !dj_used_q;
`else
    assign dj_avail = 1'b0;
`endif

    // tick_q is high exactly while the counter sits at its last value.
    always_comb begin
        cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        tick_d     = (cnt_d == CNT_LAST);
        jump_now   = jump_req_q | (key_w & ~key_w_q);
        jump_req_d = tick_q ? 1'b0 : jump_now;
    end

    always_comb begin
        pos_x_d  = pos_x_q;
        facing_d = facing_q;
        x_inc    = {1'b0, pos_x_q} + STEP_G;
        x_dec    = {1'b0, pos_x_q} - STEP_G;
        if (tick_q) begin
            if (key_d && !key_a) begin
                pos_x_d  = (x_inc > X_MAX_G) ? X_MAX_P : x_inc[W-1:0];
                facing_d = 1'b0;
            end else if (key_a && !key_d) begin
                pos_x_d  = (x_dec[W] || x_dec < X_MIN_G) ? X_MIN_P : x_dec[W-1:0];
                facing_d = 1'b1;
            end
        end
    end

    // Vertical sums use two guard bits so ceiling/floor overshoot stays signed.
    always_comb begin
        state_d = state_q;
        pos_y_d = pos_y_q;
        vy_d    = vy_q;
        y_sum   = signed'({2'b00, pos_y_q}) + signed'({vy_q[W], vy_q});
        y_jump  = signed'({2'b00, pos_y_q}) - JUMP_S;
        vy_grav = vy_q + VY_GRAV;
        if (tick_q) begin
            unique case (state_q)
                ST_GROUND: begin
                    vy_d    = '0;
                    pos_y_d = Y_GROUND_P;
                    if (jump_now) begin
                        pos_y_d = (y_jump < Y_TOP_S) ? Y_TOP_P : y_jump[W-1:0];
                        vy_d    = VY_JUMP;
                        state_d = ST_RISE;
                    end
                end
                ST_RISE, ST_FALL: begin
                    if (jump_now && dj_avail) begin
                        pos_y_d = (y_jump < Y_TOP_S) ? Y_TOP_P : y_jump[W-1:0];
                        vy_d    = VY_JUMP;
                        state_d = ST_RISE;
                    end else if (state_q == ST_RISE) begin
                        if (y_sum < Y_TOP_S) begin
                            pos_y_d = Y_TOP_P;
                            vy_d    = '0;
                            state_d = ST_FALL;
                        end else begin
                            pos_y_d = y_sum[W-1:0];
                            vy_d    = vy_grav;
                            if (!vy_grav[W]) state_d = ST_FALL;
                        end
                    end else begin
                        if (y_sum >= Y_GROUND_S) begin
                            pos_y_d = Y_GROUND_P;
                            vy_d    = '0;
                            state_d = ST_GROUND;
                        end else begin
                            pos_y_d = y_sum[W-1:0];
                            vy_d    = (vy_grav > VY_MAX) ? VY_MAX : vy_grav;
                        end
                    end
                end
                default: begin
                    state_d = ST_GROUND;
                    vy_d    = '0;
                    pos_y_d = Y_GROUND_P;
                end
            endcase
        end
    end

    assign pos_x       = pos_x_q;
    assign pos_y       = pos_y_q;
    assign airborne    = (state_q != ST_GROUND);
    assign facing_left = facing_q;
    assign tick        = tick_q;

endmodule

// File: tb/tb_player_motion_ctl.sv
// Directed bench for player_motion_ctl with a 4-clock motion tick; expected values hand-computed.
module tb_player_motion_ctl;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_a = 1'b0;
    logic         key_d = 1'b0;
    logic         key_w = 1'b0;
    logic [W-1:0] pos_x;
    logic [W-1:0] pos_y;
    logic         airborne;
    logic         facing_left;
    logic         tick;

    int n_cmp = 0;
    int n_err = 0;

    player_motion_ctl #(
        .W(W), .TICK_DIV(4), .X_MIN(0), .X_MAX(100), .X_START(50),
        .Y_TOP(0), .Y_GROUND(500), .WALK_STEP(2), .JUMP_V0(12),
        .GRAVITY(1), .VMAX_FALL(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_a(key_a), .key_d(key_d), .key_w(key_w),
        .pos_x(pos_x), .pos_y(pos_y), .airborne(airborne),
        .facing_left(facing_left), .tick(tick)
    );

    always #5 clk = ~clk;

    // Returns 1 ns after the clock edge that consumes the next tick.
    task automatic wait_tick();
        int g = 0;
        while (g < 12) begin
            @(negedge clk);
            if (tick === 1'b1) break;
            g++;
        end
        if (g >= 12) begin
            n_cmp++; n_err++;
            $display("[TB] FAIL tick_timeout: tick=%b expected 1 within 12 clocks", tick);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic do_reset();
        key_a = 1'b0; key_d = 1'b0; key_w = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_w();
        @(negedge clk);
        key_w = 1'b1;
        @(negedge clk);
        key_w = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++;
        if ({pos_x, pos_y, airborne, facing_left, tick} !== {12'd50, 12'd500, 3'b000}) begin
            n_err++;
            $display("[TB] FAIL reset_state: x=%0d y=%0d air=%b face=%b tick=%b expected 50 500 0 0 0",
                     pos_x, pos_y, airborne, facing_left, tick);
        end
    endtask

    task automatic test_walk();
        do_reset();
        key_d = 1'b1;
        wait_ticks(10);
        n_cmp++;
        if (pos_x !== 12'd70 || facing_left !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL walk_right_10: x=%0d face=%b expected 70 0", pos_x, facing_left);
        end
        wait_ticks(15);
        n_cmp++;
        if (pos_x !== 12'd100) begin
            n_err++;
            $display("[TB] FAIL walk_right_sat25: x=%0d expected 100", pos_x);
        end
        wait_ticks(5);
        n_cmp++;
        if (pos_x !== 12'd100) begin
            n_err++;
            $display("[TB] FAIL walk_right_sat30: x=%0d expected 100", pos_x);
        end
        key_a = 1'b1;
        wait_ticks(5);
        n_cmp++;
        if (pos_x !== 12'd100 || facing_left !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL both_keys_right: x=%0d face=%b expected 100 0", pos_x, facing_left);
        end
        key_d = 1'b0;
        wait_tick();
        n_cmp++;
        if (pos_x !== 12'd98 || facing_left !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL walk_left_1: x=%0d face=%b expected 98 1", pos_x, facing_left);
        end
        key_d = 1'b1;
        wait_ticks(5);
        n_cmp++;
        if (pos_x !== 12'd98 || facing_left !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL both_keys_left: x=%0d face=%b expected 98 1", pos_x, facing_left);
        end
        key_d = 1'b0;
        wait_ticks(55);
        n_cmp++;
        if (pos_x !== 12'd0 || facing_left !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL walk_left_sat: x=%0d face=%b expected 0 1", pos_x, facing_left);
        end
        key_a = 1'b0;
        // A short press that has ended before the tick edge must not move.
        @(negedge clk); key_d = 1'b1;
        @(negedge clk); key_d = 1'b0;
        wait_tick();
        n_cmp++;
        if (pos_x !== 12'd0) begin
            n_err++;
            $display("[TB] FAIL short_walk_ignored: x=%0d expected 0", pos_x);
        end
    endtask

    task automatic test_jump();
        do_reset();
        pulse_w();
        wait_tick();
        n_cmp++;
        if (pos_y !== 12'd488 || airborne !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL jump_tick1: y=%0d air=%b expected 488 1", pos_y, airborne);
        end
        wait_ticks(11);
        n_cmp++;
        if (pos_y !== 12'd422) begin
            n_err++;
            $display("[TB] FAIL jump_apex: y=%0d expected 422", pos_y);
        end
        wait_ticks(12);
        n_cmp++;
        if (pos_y !== 12'd488 || airborne !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL jump_tick24: y=%0d air=%b expected 488 1", pos_y, airborne);
        end
        wait_tick();
        n_cmp++;
        if (pos_y !== 12'd500 || airborne !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL jump_landing: y=%0d air=%b expected 500 0", pos_y, airborne);
        end
    endtask

    task automatic test_hold_jump();
        do_reset();
        @(negedge clk);
        key_w = 1'b1;
        wait_ticks(30);
        n_cmp++;
        if (pos_y !== 12'd500 || airborne !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL hold_no_rejump: y=%0d air=%b expected 500 0", pos_y, airborne);
        end
        @(negedge clk); key_w = 1'b0;
        repeat (2) @(negedge clk);
        key_w = 1'b1;
        wait_tick();
        n_cmp++;
        if (pos_y !== 12'd488 || airborne !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL repress_jump: y=%0d air=%b expected 488 1", pos_y, airborne);
        end
        key_w = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp5, exp6, exp25;
        logic         air25;
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
        exp5 = 12'd446; exp6 = 12'd435; exp25 = 12'd416; air25 = 1'b1;
`else
        exp5 = 12'd450; exp6 = 12'd443; exp25 = 12'd500; air25 = 1'b0;
`endif
        do_reset();
        pulse_w();
        wait_ticks(4);
        pulse_w();
        wait_tick();
        n_cmp++;
        if (pos_y !== exp5) begin
            n_err++;
            $display("[TB] FAIL second_press: y=%0d expected %0d", pos_y, exp5);
        end
        pulse_w();
        wait_tick();
        n_cmp++;
        if (pos_y !== exp6) begin
            n_err++;
            $display("[TB] FAIL third_press: y=%0d expected %0d", pos_y, exp6);
        end
        wait_ticks(19);
        n_cmp++;
        if (pos_y !== exp25 || airborne !== air25) begin
            n_err++;
            $display("[TB] FAIL multi_tick25: y=%0d air=%b expected %0d %b", pos_y, airborne, exp25, air25);
        end
`ifdef PLAYER_MOTION_DOUBLE_JUMP_EN
        wait_ticks(7);
        n_cmp++;
        if (pos_y !== 12'd500 || airborne !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL double_landing: y=%0d air=%b expected 500 0", pos_y, airborne);
        end
`endif
    endtask

    task automatic test_reset_mid_jump();
        do_reset();
        key_d = 1'b1;
        pulse_w();
        wait_ticks(5);
        n_cmp++;
        if (pos_x !== 12'd60 || pos_y !== 12'd450 || airborne !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL mid_jump_state: x=%0d y=%0d air=%b expected 60 450 1", pos_x, pos_y, airborne);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({pos_x, pos_y, airborne, facing_left, tick} !== {12'd50, 12'd500, 3'b000}) begin
            n_err++;
            $display("[TB] FAIL async_reset: x=%0d y=%0d air=%b face=%b tick=%b expected 50 500 0 0 0",
                     pos_x, pos_y, airborne, facing_left, tick);
        end
        key_d = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_walk();
        test_jump();
        test_hold_jump();
        test_back_to_back();
        test_reset_mid_jump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
